melody_player: RTL and testbench

- Producer side of the beat-counter interface used by the buzzer path.
- Buffers host-written note entries (note code + duration) in a small FIFO.
- Plays each entry by:
  - generating the buzzer square wave;
  - driving an external beat counter's `en` and `beat_cnt_parameter`;
  - consuming its `beat_finish` pulse to time note lengths.
- Sits between game/control logic and the buzzer pin.

---
 rtl/melody_player.sv | 128 ++++++++++++
 tb/tb_melody_player.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/melody_player.sv
// melody_player: FIFO-buffered note sequencer driving an external beat counter and a buzzer.
// Define MELODY_GAP_EN to insert GAP_TICKS of silence after every note.
module melody_player #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DEPTH      = 16,
  parameter int BEAT_TICKS = 12_500_000,
  parameter int GAP_TICKS  = 1_250_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_en,
  input  logic [4:0]  wr_note,
  input  logic [2:0]  wr_dur,
  output logic        full,
  input  logic        play,
  output logic        busy,
  output logic [4:0]  cur_note,
  output logic        beat_en,
  output logic [27:0] beat_cnt_parameter,
  input  logic        beat_finish,
  output logic        buzzer
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [27:0] BEAT_PARAM = 28'(BEAT_TICKS - 1);
  localparam logic [27:0] GAP_PARAM = 28'(GAP_TICKS - 1);
`ifdef MELODY_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif
  localparam int FREQ [21] = '{262, 294, 330, 349, 392, 440, 494,
                               523, 587, 659, 698, 784, 880, 988,
                               1047, 1175, 1319, 1397, 1568, 1760, 1976};
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  function automatic logic is_tone(input logic [4:0] n);
    return n != 5'd0 && n <= 5'd21;
  endfunction
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  state_t state;
  logic [4:0] note, head_note;
  logic [2:0] beats_left;
  logic [19:0] tone_cnt, half;
  logic [19:0] half_tab [21];
  logic push, pop, empty, tone, next_load, wrap;
  for (genvar i = 0; i < 21; i++) begin : g_half
    assign half_tab[i] = 20'(CLK_HZ / (2 * FREQ[i]));
  end
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign push = wr_en && !full;
  assign pop = state == LOAD;
  assign busy = state != IDLE;
  assign head_note = mem[rp][7:3];
  assign tone = is_tone(note);
  assign half = half_tab[tone ? note - 5'd1 : 5'd0];
  assign wrap = tone_cnt == half - 20'd1;
  assign next_load = play && !empty;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {wr_note, wr_dur};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      note <= '0;
      beats_left <= '0;
      tone_cnt <= '0;
      buzzer <= 1'b0;
      beat_en <= 1'b0;
      cur_note <= '0;
      beat_cnt_parameter <= BEAT_PARAM;
    end else begin
      case (state)
        IDLE: begin
          beat_en <= 1'b0;
          buzzer <= 1'b0;
          cur_note <= '0;
          if (next_load) state <= LOAD;
        end
        LOAD: begin
          note <= head_note;
          beats_left <= mem[rp][2:0];
          tone_cnt <= '0;
          buzzer <= 1'b0;
          beat_en <= 1'b1;
          beat_cnt_parameter <= BEAT_PARAM;
          cur_note <= is_tone(head_note) ? head_note : 5'd0;
          state <= PLAY;
        end
        PLAY: begin
          if (tone) begin
            tone_cnt <= wrap ? 20'd0 : tone_cnt + 20'd1;
            if (wrap) buzzer <= ~buzzer;
          end
          if (beat_finish) begin
            if (beats_left != 3'd0) beats_left <= beats_left - 3'd1;
            else begin
              buzzer <= 1'b0;
              cur_note <= '0;
              tone_cnt <= '0;
              if (GAP_ON) begin
                state <= GAP;
                beat_cnt_parameter <= GAP_PARAM;
              end else begin
                beat_en <= 1'b0;
                state <= next_load ? LOAD : IDLE;
              end
            end
          end
        end
        default: if (beat_finish) begin
          beat_en <= 1'b0;
          beat_cnt_parameter <= BEAT_PARAM;
          state <= next_load ? LOAD : IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: random note streams checked against a queue-based model of the player.
module tb_melody_player;
  localparam int DEPTH = 4;
  localparam int BEAT = 8;
`ifdef MELODY_GAP_EN
  localparam int GAP = 4;
`else
  localparam int GAP = 0;
`endif
  localparam int FREQ [21] = '{262, 294, 330, 349, 392, 440, 494,
                               523, 587, 659, 698, 784, 880, 988,
                               1047, 1175, 1319, 1397, 1568, 1760, 1976};
  logic clk, rstn, wr_en, full, play, busy, beat_en, beat_finish, buzzer;
  logic [4:0] wr_note, cur_note;
  logic [2:0] wr_dur;
  logic [27:0] beat_cnt_parameter, bc;
  int n_checks, n_fail;
  logic [7:0] model_q [$];

  melody_player #(.CLK_HZ(20000), .DEPTH(DEPTH), .BEAT_TICKS(BEAT), .GAP_TICKS(4)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_note(wr_note), .wr_dur(wr_dur),
    .full(full), .play(play), .busy(busy), .cur_note(cur_note), .beat_en(beat_en),
    .beat_cnt_parameter(beat_cnt_parameter), .beat_finish(beat_finish), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  // external beat counter: one beat = parameter+1 enabled clocks
  assign beat_finish = beat_en && bc == beat_cnt_parameter;
  always @(posedge clk or negedge rstn)
    if (!rstn) bc <= '0;
    else if (beat_en) bc <= beat_finish ? 28'd0 : bc + 28'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [4:0] n, input logic [2:0] d);
    wr_note = n;
    wr_dur = d;
    wr_en = 1'b1;
    @(posedge clk);
    if (model_q.size() < DEPTH) model_q.push_back({n, d});
    @(negedge clk);
    wr_en = 1'b0;
    check("full", full, model_q.size() == DEPTH);
  endtask

  task automatic push_rand();
    push(5'($urandom_range(0, 31)), 3'($urandom_range(0, 3)));
  endtask

  // observe one note from beat_en rising to falling against the model head
  task automatic observe(input int exp_idle, input int drop_at);
    int idle, len, e_note, e_buz, e_par, half, tone_len;
    logic [7:0] ent;
    logic [4:0] n;
    logic [2:0] d;
    logic tone, in_note;
    idle = 0; len = 0; e_note = 0; e_buz = 0; e_par = 0; ent = '0;
    while (!beat_en && idle < 300) begin
      @(negedge clk);
      idle++;
    end
    check("note_start", beat_en, 1);
    if (exp_idle >= 0) check("latency", idle, exp_idle);
    if (model_q.size() > 0) ent = model_q.pop_front();
    n = ent[7:3];
    d = ent[2:0];
    tone = n != 0 && n <= 21;
    half = tone ? 20000 / (2 * FREQ[n - 1]) : 1;
    tone_len = (d + 1) * BEAT;
    while (beat_en && len < 800) begin
      in_note = len < tone_len;
      if (cur_note !== ((in_note && tone) ? n : 5'd0)) e_note++;
      if (buzzer !== ((in_note && tone) ? 1'((len / half) % 2) : 1'b0)) e_buz++;
      if (beat_cnt_parameter !== (in_note ? 28'(BEAT - 1) : 28'(GAP - 1))) e_par++;
      if (len == drop_at) play = 1'b0;
      @(negedge clk);
      len++;
    end
    check("beat_len", len, tone_len + GAP);
    check("cur_note_err", e_note, 0);
    check("buzzer_err", e_buz, 0);
    check("param_err", e_par, 0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int hi;
    hi = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (beat_en) hi++;
    end
    check(tag, hi, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    clk = 0; rstn = 0; wr_en = 0; wr_note = 0; wr_dur = 0; play = 0;
    n_checks = 0; n_fail = 0;
    repeat (2) @(negedge clk);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_cur_note", cur_note, 0);
    check("rst_beat_en", beat_en, 0);
    check("rst_param", beat_cnt_parameter, BEAT - 1);
    check("rst_buzzer", buzzer, 0);
    rstn = 1;
    @(negedge clk);
    // A4, one beat, with explicit LOAD-cycle checks
    push(5'd6, 3'd0);
    play = 1;
    @(negedge clk);
    check("load_busy", busy, 1);
    check("load_beat_en", beat_en, 0);
    observe(1, -1);
    check("idle_busy", busy, 0);
    play = 0;
    // rest, three beats
    push(5'd0, 3'd2);
    play = 1;
    observe(2, -1);
    play = 0;
    // overfill: fifth write dropped, exactly four notes play
    repeat (5) push_rand();
    play = 1;
    observe(2, -1);
    repeat (3) observe(1, -1);
    play = 0;
    quiet("no_fifth_note", 40);
    check("drained_busy", busy, 0);
    // two equal notes back to back
    push(5'd1, 3'd0);
    push(5'd1, 3'd0);
    play = 1;
    observe(2, -1);
    observe(1, -1);
    play = 0;
    // random bursts
    for (int r = 0; r < 4; r++) begin
      k = $urandom_range(1, 3);
      repeat (k) push_rand();
      play = 1;
      observe(2, -1);
      repeat (k - 1) observe(1, -1);
      play = 0;
    end
    // dropping play mid-note lets it finish, second stays queued
    repeat (2) push_rand();
    play = 1;
    observe(2, 3);
    quiet("drop_hold", 40);
    check("drop_busy", busy, 0);
    play = 1;
    observe(2, -1);
    play = 0;
    // reset mid-note with a full FIFO
    push(5'($urandom_range(8, 21)), 3'd3);
    push_rand();
    play = 1;
    k = 0;
    while (!beat_en && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rst_note_start", beat_en, 1);
    if (model_q.size() > 0) void'(model_q.pop_front());
    repeat (3) push_rand();
    k = 0;
    while (!buzzer && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("buzzer_high", buzzer, 1);
    rstn = 0;
    #1;
    check("mid_rst_buzzer", buzzer, 0);
    check("mid_rst_beat_en", beat_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_cur_note", cur_note, 0);
    model_q.delete();
    @(negedge clk);
    rstn = 1;
    quiet("post_rst_empty", 30);
    check("post_rst_full", full, 0);
    check("post_rst_busy", busy, 0);
    play = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
